eth_rx_idma_req_gen: RTL and testbench

// - RX-side AXI-Stream pass-through stage. Sits between the Ethernet MAC RX stream and the clk_i-side RX CDC/iDMA path.
// - Counts bytes of each received frame. On tlast, queues the frame length.
// - Sequences one iDMA stream->AXI request per frame into a ring of NumSlots equal slots in memory.
// - Reports each completed frame (slot, length, error) to the host.

---
 rtl/eth_rx_idma_req_gen_if.sv | 46 ++++
 rtl/eth_rx_idma_req_gen.sv | 168 ++++++++++++++++
 tb/tb_eth_rx_idma_req_gen.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/eth_rx_idma_req_gen_if.sv
// eth_rx_idma_req_gen_if: stream, iDMA request/response and completion handshakes.
// slave is the request generator's view, master is the surrounding environment.
interface eth_rx_idma_req_gen_if #(
   parameter int DataWidth = 32,
   parameter int AddrWidth = 32,
   parameter int LenWidth  = 16,
   parameter int NumSlots  = 8
);
   localparam int SW = $clog2(NumSlots);
   logic [DataWidth-1:0]   s_tdata_i;
   logic [DataWidth/8-1:0] s_tkeep_i;
   logic                   s_tlast_i;
   logic                   s_tvalid_i;
   logic                   s_tready_o;
   logic [DataWidth-1:0]   m_tdata_o;
   logic [DataWidth/8-1:0] m_tkeep_o;
   logic                   m_tlast_o;
   logic                   m_tvalid_o;
   logic                   m_tready_i;
   logic                   req_valid_o;
   logic                   req_ready_i;
   logic [AddrWidth-1:0]   req_dst_addr_o;
   logic [LenWidth-1:0]    req_length_o;
   logic                   rsp_valid_i;
   logic                   rsp_ready_o;
   logic                   rsp_error_i;
   logic                   done_valid_o;
   logic                   done_ready_i;
   logic [SW-1:0]          done_slot_o;
   logic [LenWidth-1:0]    done_len_o;
   logic                   done_error_o;
   modport slave (
      input  s_tdata_i, s_tkeep_i, s_tlast_i, s_tvalid_i, m_tready_i,
             req_ready_i, rsp_valid_i, rsp_error_i, done_ready_i,
      output s_tready_o, m_tdata_o, m_tkeep_o, m_tlast_o, m_tvalid_o,
             req_valid_o, req_dst_addr_o, req_length_o, rsp_ready_o,
             done_valid_o, done_slot_o, done_len_o, done_error_o
   );
   modport master (
      output s_tdata_i, s_tkeep_i, s_tlast_i, s_tvalid_i, m_tready_i,
             req_ready_i, rsp_valid_i, rsp_error_i, done_ready_i,
      input  s_tready_o, m_tdata_o, m_tkeep_o, m_tlast_o, m_tvalid_o,
             req_valid_o, req_dst_addr_o, req_length_o, rsp_ready_o,
             done_valid_o, done_slot_o, done_len_o, done_error_o
   );
endinterface

// File: rtl/eth_rx_idma_req_gen.sv
// eth_rx_idma_req_gen: RX stream pass-through that issues one iDMA request per frame into a slot ring.
// Define ETH_RX_REQGEN_STATS_EN to add frame/byte/drop statistics counters.
module eth_rx_idma_req_gen #(
   parameter int DataWidth    = 32,
   parameter int AddrWidth    = 32,
   parameter int LenWidth     = 16,
   parameter int NumSlots     = 8,
   parameter int LenFifoDepth = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   eth_rx_idma_req_gen_if.slave bus,
   input  logic                 enable_i,
   input  logic [AddrWidth-1:0] ring_base_i,
   input  logic [4:0]           slot_log2_i,
   input  logic                 slot_release_i,
   output logic                 busy_o
`ifdef ETH_RX_REQGEN_STATS_EN
   ,
   output logic [31:0]          stat_frames_o,
   output logic [31:0]          stat_bytes_o,
   output logic [15:0]          stat_drops_o
`endif
);
   localparam int KW = DataWidth / 8;
   localparam int SW = $clog2(NumSlots);
   localparam int FW = $clog2(LenFifoDepth);
   localparam int CW = $clog2(KW + 1);
   typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} state_t;
   state_t               r_state;
   logic [LenWidth-1:0]  r_byte_cnt;
   logic                 r_ovf_acc;
   logic [LenWidth-1:0]  r_fifo_len [LenFifoDepth];
   logic                 r_fifo_ovf [LenFifoDepth];
   logic [FW-1:0]        r_wp, r_rp;
   logic [FW:0]          r_cnt;
   logic [SW:0]          r_occ;
   logic [SW-1:0]        r_wr_slot;
   logic                 r_ovf;
   logic                 r_req_valid, r_rsp_ready, r_done_valid, r_done_err;
   logic [AddrWidth-1:0] r_req_addr;
   logic [LenWidth-1:0]  r_req_len, r_done_len;
   logic [SW-1:0]        r_done_slot;
   logic [CW-1:0]        w_keep_cnt;
   logic [LenWidth:0]    w_sum;
   logic                 w_sat, w_full, w_acc, w_push, w_push_ovf, w_fifo_pop, w_done_hs, w_rel;
   logic [LenWidth-1:0]  w_len;
   logic [32:0]          w_slot_bytes;
   always_comb begin
      w_keep_cnt = '0;
      for (int i = 0; i < KW; i++) w_keep_cnt = w_keep_cnt + CW'(bus.s_tkeep_i[i]);
   end
   assign w_sum        = {1'b0, r_byte_cnt} + (LenWidth+1)'(w_keep_cnt);
   assign w_sat        = w_sum[LenWidth];
   assign w_len        = w_sat ? '1 : w_sum[LenWidth-1:0];
   assign w_slot_bytes = 33'd1 << slot_log2_i;
   assign w_full       = r_cnt == (FW+1)'(LenFifoDepth);
   assign w_acc        = bus.s_tvalid_i & bus.s_tready_o;
   assign w_push       = w_acc & bus.s_tlast_i;
   assign w_push_ovf   = r_ovf_acc | w_sat | (33'(w_len) > w_slot_bytes);
   assign w_fifo_pop   = (r_state == IDLE) & (r_cnt != '0) & enable_i & (r_occ < (SW+1)'(NumSlots));
   assign w_done_hs    = r_done_valid & bus.done_ready_i;
   assign w_rel        = slot_release_i & (r_occ != '0);
   assign bus.m_tdata_o      = bus.s_tdata_i;
   assign bus.m_tkeep_o      = bus.s_tkeep_i;
   assign bus.m_tlast_o      = bus.s_tlast_i;
   assign bus.m_tvalid_o     = bus.s_tvalid_i & ~w_full;
   assign bus.s_tready_o     = bus.m_tready_i & ~w_full;
   assign bus.req_valid_o    = r_req_valid;
   assign bus.req_dst_addr_o = r_req_addr;
   assign bus.req_length_o   = r_req_len;
   assign bus.rsp_ready_o    = r_rsp_ready;
   assign bus.done_valid_o   = r_done_valid;
   assign bus.done_slot_o    = r_done_slot;
   assign bus.done_len_o     = r_done_len;
   assign bus.done_error_o   = r_done_err;
   assign busy_o             = (r_state != IDLE) | (r_cnt != '0);
   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_fifo_len[r_wp] <= w_len;
         r_fifo_ovf[r_wp] <= w_push_ovf;
      end
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state      <= IDLE;
         r_byte_cnt   <= '0;
         r_ovf_acc    <= 1'b0;
         r_wp         <= '0;
         r_rp         <= '0;
         r_cnt        <= '0;
         r_occ        <= '0;
         r_wr_slot    <= '0;
         r_ovf        <= 1'b0;
         r_req_valid  <= 1'b0;
         r_rsp_ready  <= 1'b0;
         r_done_valid <= 1'b0;
         r_done_err   <= 1'b0;
         r_req_addr   <= '0;
         r_req_len    <= '0;
         r_done_len   <= '0;
         r_done_slot  <= '0;
      end else begin
         if (w_acc) begin
            r_byte_cnt <= w_push ? '0 : w_len;
            r_ovf_acc  <= w_push ? 1'b0 : r_ovf_acc | w_sat;
         end
         r_wp  <= r_wp + FW'(w_push);
         r_rp  <= r_rp + FW'(w_fifo_pop);
         r_cnt <= r_cnt + (FW+1)'(w_push) - (FW+1)'(w_fifo_pop);
         r_occ <= r_occ + (SW+1)'(w_done_hs) - (SW+1)'(w_rel);
         case (r_state)
            IDLE: if (w_fifo_pop) begin
               r_ovf <= r_fifo_ovf[r_rp];
               // An empty frame has nothing to move; complete it as an error.
               if (r_fifo_len[r_rp] == '0) begin
                  r_state      <= DONE;
                  r_done_valid <= 1'b1;
                  r_done_slot  <= r_wr_slot;
                  r_done_len   <= '0;
                  r_done_err   <= 1'b1;
               end else begin
                  r_state     <= REQ;
                  r_req_valid <= 1'b1;
                  r_req_addr  <= ring_base_i + (AddrWidth'(r_wr_slot) << slot_log2_i);
                  r_req_len   <= r_fifo_len[r_rp];
               end
            end
            REQ: if (bus.req_ready_i) begin
               r_req_valid <= 1'b0;
               r_rsp_ready <= 1'b1;
               r_state     <= RSP;
            end
            RSP: if (bus.rsp_valid_i) begin
               r_rsp_ready  <= 1'b0;
               r_done_valid <= 1'b1;
               r_done_slot  <= r_wr_slot;
               r_done_len   <= r_req_len;
               r_done_err   <= bus.rsp_error_i | r_ovf;
               r_state      <= DONE;
            end
            DONE: if (bus.done_ready_i) begin
               r_done_valid <= 1'b0;
               r_wr_slot    <= r_wr_slot + SW'(1);
               r_state      <= IDLE;
            end
         endcase
      end
   end
`ifdef ETH_RX_REQGEN_STATS_EN
   logic [31:0] r_frames, r_bytes;
   logic [15:0] r_drops;
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_frames <= '0;
         r_bytes  <= '0;
         r_drops  <= '0;
      end else begin
         r_frames <= r_frames + 32'(w_push);
         r_bytes  <= r_bytes + (w_acc ? 32'(w_keep_cnt) : 32'd0);
         r_drops  <= r_drops + 16'(w_done_hs & r_done_err);
      end
   end
   assign stat_frames_o = r_frames;
   assign stat_bytes_o  = r_bytes;
   assign stat_drops_o  = r_drops;
`endif
endmodule

// File: tb/tb_eth_rx_idma_req_gen.sv
// tb_eth_rx_idma_req_gen: directed + randomized checks of the RX iDMA request generator
// against a frame-level model (queued lengths, ring slot index, slot occupancy).
module tb_eth_rx_idma_req_gen;
   logic        clk = 1'b0;
   logic        rst;
   logic        enable, release_p, busy;
   logic [31:0] base;
   logic [4:0]  slot_log2;
   int          errors = 0, checks = 0, slot = 0, pushed = 0;
   int          q_len[$];
   always #5 clk = ~clk;
   eth_rx_idma_req_gen_if bus ();
`ifdef ETH_RX_REQGEN_STATS_EN
   logic [31:0] stat_frames, stat_bytes;
   logic [15:0] stat_drops;
`endif
   eth_rx_idma_req_gen dut (
      .clk_i(clk), .rst_i(rst), .bus(bus), .enable_i(enable), .ring_base_i(base),
      .slot_log2_i(slot_log2), .slot_release_i(release_p), .busy_o(busy)
`ifdef ETH_RX_REQGEN_STATS_EN
      , .stat_frames_o(stat_frames), .stat_bytes_o(stat_bytes), .stat_drops_o(stat_drops)
`endif
   );
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic send_beat(input logic [31:0] data, input logic [3:0] keep, input logic last);
      int n = 0;
      if ($urandom_range(3) == 0) begin
         bus.s_tvalid_i = 1'b0;
         tick();
      end
      bus.s_tdata_i = data;
      bus.s_tkeep_i = keep;
      bus.s_tlast_i = last;
      bus.s_tvalid_i = 1'b1;
      #1;
      chk("pass_through", {bus.m_tdata_o, bus.m_tkeep_o, bus.m_tlast_o}, {data, keep, last});
      while (!bus.s_tready_o && n < 200) begin
         tick();
         n++;
      end
      chk("beat_accept", bus.s_tready_o, 1);
      tick();
      bus.s_tvalid_i = 1'b0;
      bus.s_tlast_i = 1'b0;
   endtask
   task automatic send_frame(input int len);
      int nb = (len == 0) ? 1 : (len + 3) / 4;
      for (int b = 0; b < nb; b++) begin
         int rem = len - 4 * b;
         logic [3:0] k;
         k = (rem >= 4) ? 4'hF : 4'((1 << rem) - 1);
         send_beat($urandom, k, b == nb - 1);
      end
      q_len.push_back(len);
      pushed++;
   endtask
   task automatic serve(input logic err, input logic rel);
      int n = 0;
      int len;
      logic exp_err;
      len = q_len.pop_front();
      exp_err = (len == 0) || err || (len > (1 << slot_log2));
      if (len != 0) begin
         while (!bus.req_valid_o && n < 100) begin
            tick();
            n++;
         end
         chk("req_valid", bus.req_valid_o, 1);
         chk("req_dst", bus.req_dst_addr_o, 32'(base + slot * (1 << slot_log2)));
         chk("req_len", bus.req_length_o, len);
         repeat ($urandom_range(2)) tick();
         bus.req_ready_i = 1'b1;
         tick();
         bus.req_ready_i = 1'b0;
         chk("rsp_ready", bus.rsp_ready_o, 1);
         repeat ($urandom_range(2)) tick();
         bus.rsp_valid_i = 1'b1;
         bus.rsp_error_i = err;
         tick();
         bus.rsp_valid_i = 1'b0;
         bus.rsp_error_i = 1'b0;
      end
      n = 0;
      while (!bus.done_valid_o && n < 100) begin
         tick();
         n++;
      end
      chk("done_valid", bus.done_valid_o, 1);
      chk("done_slot", bus.done_slot_o, slot);
      chk("done_len", bus.done_len_o, len);
      chk("done_error", bus.done_error_o, exp_err);
      bus.done_ready_i = 1'b1;
      release_p = rel;
      tick();
      bus.done_ready_i = 1'b0;
      release_p = 1'b0;
      chk("done_clear", bus.done_valid_o, 0);
      slot = (slot + 1) % 8;
   endtask
   task automatic release_slot();
      release_p = 1'b1;
      tick();
      release_p = 1'b0;
   endtask
   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_ctrl"}, {bus.req_valid_o, bus.rsp_ready_o, bus.done_valid_o, busy}, 0);
      chk({tag, "_req"}, {bus.req_dst_addr_o, bus.req_length_o}, 0);
      chk({tag, "_done"}, {bus.done_slot_o, bus.done_len_o, bus.done_error_o}, 0);
   endtask
   initial begin
      int n;
      rst = 1'b1;
      enable = 1'b1;
      release_p = 1'b0;
      base = 32'h8000_0000;
      slot_log2 = 5'd11;
      bus.s_tdata_i = '0;
      bus.s_tkeep_i = '0;
      bus.s_tlast_i = 1'b0;
      bus.s_tvalid_i = 1'b0;
      bus.m_tready_i = 1'b1;
      bus.req_ready_i = 1'b0;
      bus.rsp_valid_i = 1'b0;
      bus.rsp_error_i = 1'b0;
      bus.done_ready_i = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      chk_idle_outputs("reset");
      chk("reset_tready", bus.s_tready_o, 1);
      send_frame(64);
      serve(1'b0, 1'b0);
      release_slot();
      for (int i = 0; i < 6; i++) begin
         send_frame($urandom_range(1, 300));
         serve(i == 2 || $urandom_range(4) == 0, 1'b0);
         release_slot();
      end
      send_frame(61);
      serve(1'b0, 1'b0);
      release_slot();
      send_frame($urandom_range(1, 200));
      serve(1'b0, 1'b0);
      release_slot();
      send_frame(3000);
      serve(1'b0, 1'b0);
      release_slot();
      send_frame(2048);
      serve(1'b0, 1'b0);
      release_slot();
      send_frame(2049);
      serve(1'b0, 1'b0);
      release_slot();
      send_frame(0);
      serve(1'b0, 1'b0);
      release_slot();
      send_frame($urandom_range(1, 100));
      send_frame($urandom_range(1, 100));
      serve(1'b0, 1'b0);
      serve(1'b1, 1'b0);
      release_slot();
      release_slot();
      for (int i = 0; i < 8; i++) begin
         send_frame($urandom_range(1, 64));
         serve($urandom_range(3) == 0, 1'b0);
      end
      send_frame(20);
      repeat (5) tick();
      chk("ring_full_req", bus.req_valid_o, 0);
      chk("ring_full_busy", busy, 1);
      for (int i = 0; i < 3; i++) send_frame($urandom_range(1, 40));
      chk("fifo_full_tready", bus.s_tready_o, 0);
      bus.s_tvalid_i = 1'b1;
      #1;
      chk("fifo_full_tvalid", bus.m_tvalid_o, 0);
      bus.s_tvalid_i = 1'b0;
      release_slot();
      n = 0;
      while (!bus.req_valid_o && n < 2) begin
         tick();
         n++;
      end
      chk("release_issue", bus.req_valid_o, 1);
      chk("release_tready", bus.s_tready_o, 1);
      rst = 1'b1;
      tick();
      chk_idle_outputs("mid_req_reset");
      rst = 1'b0;
      q_len.delete();
      slot = 0;
      pushed = 0;
      for (int i = 0; i < 3; i++) begin
         send_frame($urandom_range(1, 150));
         serve(1'b0, 1'b0);
      end
      send_frame($urandom_range(1, 150));
      serve(1'b0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         send_frame($urandom_range(1, 80));
         serve(1'b0, 1'b0);
      end
      send_frame(33);
      repeat (6) tick();
      chk("occupancy_block", bus.req_valid_o, 0);
      release_slot();
      serve(1'b0, 1'b0);
`ifdef ETH_RX_REQGEN_STATS_EN
      chk("stat_frames", stat_frames, pushed);
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
